// File: rtl/adapter_axi_stream_2_block_fifo.sv
// AXI Stream to ping-pong Block FIFO write adapter: owns one free half at a time,
// streams beats into it and commits on full, tlast, empty-size or idle timeout.
module adapter_axi_stream_2_block_fifo #(
    parameter int DATA_WIDTH      = 24,
    parameter int USER_DATA_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic                       i_axi_clk,
    input  logic                       rst,
    input  logic [1:0]                 i_block_fifo_rdy,
    output logic [1:0]                 o_block_fifo_act,
    input  logic [23:0]                i_block_fifo_size,
    output logic                       o_block_fifo_stb,
    output logic [DATA_WIDTH:0]        o_block_fifo_data,
    input  logic [USER_DATA_WIDTH-1:0] i_axi_user,
    input  logic [DATA_WIDTH-1:0]      i_axi_data,
    input  logic                       i_axi_valid,
    input  logic                       i_axi_last,
    output logic                       o_axi_ready,
    output logic [31:0]                o_debug
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_READY   = 4'd1,
        ST_RELEASE = 4'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [1:0]           act_reg, act_next;
    logic [23:0]          count_reg, count_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic                 last_ch_reg, last_ch_next;
    logic                 timeout_fired_reg, timeout_fired_next;

    logic                 accept;
    logic [24:0]          count_inc;
    logic                 pick_half;
    logic [1:0]           pick_onehot;
    logic                 timer_sat;
    logic [TIMER_W-1:0]   timer_inc;
    logic [3:0]           state_bits;
    logic                 unused_user;

    assign o_axi_ready       = (state_reg == ST_READY) && (act_reg != 2'b00)
                               && (count_reg < i_block_fifo_size);
    assign accept            = i_axi_valid & o_axi_ready;
    assign o_block_fifo_stb  = accept;
    assign o_block_fifo_data = {i_axi_user[0], i_axi_data};
    assign o_block_fifo_act  = act_reg;
    assign unused_user       = ^i_axi_user;

    // 25-bit increment so a full-scale size cannot wrap the full-block test
    assign count_inc = {1'b0, count_reg} + 25'd1;
    assign timer_sat = (timer_reg == TIMER_MAX);
    assign timer_inc = timer_reg + TIMER_W'(1);

    // With both halves free, alternate away from the half committed last
    always_comb begin
        pick_half = ~last_ch_reg;
        case (i_block_fifo_rdy)
            2'b01:   pick_half = 1'b0;
            2'b10:   pick_half = 1'b1;
            default: pick_half = ~last_ch_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pick
            assign pick_onehot[gi] = (pick_half == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next         = state_reg;
        act_next           = act_reg;
        count_next         = count_reg;
        timer_next         = timer_reg;
        last_ch_next       = last_ch_reg;
        timeout_fired_next = timeout_fired_reg;
        case (state_reg)
            ST_IDLE: begin
                if ((i_block_fifo_rdy != 2'b00) && (act_reg == 2'b00)) begin
                    act_next           = pick_onehot;
                    count_next         = 24'd0;
                    timer_next         = '0;
                    timeout_fired_next = 1'b0;
                    state_next         = ST_READY;
                end
            end
            ST_READY: begin
                if (accept) begin
                    count_next = count_inc[23:0];
                    timer_next = '0;
                    if ((count_inc >= {1'b0, i_block_fifo_size}) || i_axi_last) begin
                        act_next     = 2'b00;
                        last_ch_next = act_reg[1];
                        state_next   = ST_RELEASE;
                    end
                end else if (count_reg >= i_block_fifo_size) begin
                    act_next     = 2'b00;
                    last_ch_next = act_reg[1];
                    state_next   = ST_RELEASE;
                end else begin
                    if (TIMEOUT_EN && !timer_sat) begin
                        timer_next = timer_inc;
                    end
                    // An empty block never times out; the timer just saturates
                    if (TIMEOUT_EN && !timer_sat && (count_reg != 24'd0)
                        && (timer_inc == TIMER_MAX)) begin
                        act_next           = 2'b00;
                        last_ch_next       = act_reg[1];
                        timeout_fired_next = 1'b1;
                        state_next         = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                act_next   = 2'b00;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= ST_IDLE;
            act_reg           <= 2'b00;
            count_reg         <= 24'd0;
            timer_reg         <= '0;
            last_ch_reg       <= 1'b1;
            timeout_fired_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            act_reg           <= act_next;
            count_reg         <= count_next;
            timer_reg         <= timer_next;
            last_ch_reg       <= last_ch_next;
            timeout_fired_reg <= timeout_fired_next;
        end
    end

    assign state_bits = state_reg;
    assign o_debug    = {8'd0, count_reg[7:0], 6'd0, timeout_fired_reg, last_ch_reg,
                         i_block_fifo_rdy, act_reg, state_bits};

endmodule
